tspi_master: RTL and testbench
==============================

// Module: tspi_master
// PURPOSE
//  Ternary serial master that drives the O_mosi/O_sck pins and samples I_miso of top.
//  A parallel word of TRITS balanced trits goes out MSB-trit first while TRITS trits are captured.
//  The result is returned as a parallel word for the compare333_3-style logic downstream.
//  Trit code everywhere: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = illegal.
// PARAMETERS
//  TRITS    9  trits per transfer (>=1); word width W = 2*TRITS bits
//  CLK_DIV  4  I_clk cycles per sck phase (>=1)
// PORTS
//  I_clk      in   1  single clock; all state changes on rising edge
//  I_rst      in   1  synchronous, active-high reset
//  I_start    in   1  request a transfer; honoured only in IDLE
//  I_tx_data  in   W  word to send; trit k = bits [2k+1:2k]; trit TRITS-1 is sent first
//  O_busy     out  1  high while a transfer is in progress
//  O_done     out  1  one-cycle pulse; transfer complete, O_rx_data valid
//  O_rx_data  out  W  received word, same trit ordering as I_tx_data
//  O_err      out  1  sticky: an illegal trit (11) was sampled on I_miso
//  O_mosi     out  2  serial data trit
//  I_miso     in   2  serial return trit
//  O_sck      out  2  ternary clock: 00 idle, 01 drive phase, 10 sample phase
// BEHAVIOUR
//  Reset (I_rst=1 at an edge): state IDLE; O_busy=0, O_done=0, O_rx_data=0, O_err=0,
//   O_mosi=00, O_sck=00. This also applies mid-transfer: the transfer is aborted,
//   no O_done pulse is issued, and received trits are discarded.
//  States: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  IDLE: when I_start=1, latch I_tx_data into the tx shift register.
//   An illegal 11 trit is latched as 00. Clear O_err and the trit counter, then go to DRIVE.
//   O_busy=1 from the next cycle.
//  DRIVE: O_sck=01, O_mosi = current tx trit. Lasts exactly CLK_DIV cycles.
//  SAMPLE: O_sck=10, O_mosi held. On the last of its CLK_DIV cycles, shift I_miso into the
//   rx register at the LSB end. If I_miso=11, store 00 and set O_err.
//   Then, if trits sent < TRITS, advance the tx register and go to DRIVE; otherwise go to DONE.
//  DONE: one cycle. O_done=1, O_rx_data <= rx register, O_busy=0, O_sck=00, O_mosi=00.
//   Then go to IDLE.
//  Latency: with I_start seen at edge 0, O_done is high in cycle 2*CLK_DIV*TRITS+1.
//   The next I_start is accepted at the edge after O_done.
//  I_start while busy or in DONE: ignored, not queued.
//  O_rx_data holds its value between transfers; it changes only in DONE or on reset.
//  O_err holds its value until the next accepted I_start or reset.
//  The phase counter and trit counter wrap only through the state transitions above,
//   never freely.
// TESTING (TRITS=3, CLK_DIV=2)
//  Reset then idle: after reset, all outputs are 0; O_mosi/O_sck stay 00 for 20 cycles with
//   no I_start.
//  Loopback: tie I_miso=O_mosi, start with tx=6'b01_10_00 -> O_mosi sequence 01,10,00;
//   O_done at cycle 13; O_rx_data=6'b011000; O_err=0.
//  Illegal rx: start, force I_miso=11 on the 2nd sample -> O_rx_data middle trit =00,
//   O_err=1, cleared on next start.
//  Busy start: pulse I_start at cycle 5 of a transfer -> ignored; exactly one O_done;
//   O_busy low right after.
//  Reset mid-transfer: assert I_rst at cycle 7 -> next cycle all outputs 0; no O_done;
//   a fresh start works.
//  Back-to-back: assert I_start the cycle after O_done with tx=6'b10_10_10 (loopback) ->
//   accepted; O_rx_data=6'b101010.

Source files
------------

// File: rtl/tspi_master.sv
// tspi_master: ternary serial master, shifts TRITS balanced trits out MSB-first while capturing I_miso
module tspi_master #(
  parameter int TRITS = 9,
  parameter int CLK_DIV = 4
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_start,
  input  logic [2*TRITS-1:0]   I_tx_data,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [2*TRITS-1:0]   O_rx_data,
  output logic                 O_err,
  output logic [1:0]           O_mosi,
  input  logic [1:0]           I_miso,
  output logic [1:0]           O_sck
);
  localparam int W = 2 * TRITS;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int TW = TRITS > 1 ? $clog2(TRITS) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state;
  logic [W-1:0] tx, rx, tx_clean, tx_adv, rx_next;
  logic [1:0] miso_clean;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic pend;
  always_comb begin
    tx_clean = I_tx_data;
    for (int k = 0; k < TRITS; k++)
      tx_clean[2*k+:2] = &I_tx_data[2*k+:2] ? 2'b00 : I_tx_data[2*k+:2];
  end
  assign miso_clean = &I_miso ? 2'b00 : I_miso;
  assign tx_adv = tx << 2;
  assign rx_next = (rx << 2) | W'(miso_clean);
  assign pend = pcnt == PW'(CLK_DIV - 1);
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= IDLE;
      tx <= '0;
      rx <= '0;
      pcnt <= '0;
      tcnt <= '0;
      O_busy <= 1'b0;
      O_done <= 1'b0;
      O_rx_data <= '0;
      O_err <= 1'b0;
      O_mosi <= 2'b00;
      O_sck <= 2'b00;
    end else begin
      case (state)
        IDLE: if (I_start) begin
          tx <= tx_clean;
          rx <= '0;
          O_err <= 1'b0;
          tcnt <= '0;
          pcnt <= '0;
          O_busy <= 1'b1;
          O_sck <= 2'b01;
          O_mosi <= tx_clean[W-1:W-2];
          state <= DRIVE;
        end
        DRIVE: if (pend) begin
          pcnt <= '0;
          O_sck <= 2'b10;
          state <= SAMPLE;
        end else pcnt <= pcnt + PW'(1);
        SAMPLE: if (pend) begin
          pcnt <= '0;
          rx <= rx_next;
          if (&I_miso) O_err <= 1'b1;
          if (tcnt == TW'(TRITS - 1)) begin
            O_done <= 1'b1;
            O_rx_data <= rx_next;
            O_busy <= 1'b0;
            O_sck <= 2'b00;
            O_mosi <= 2'b00;
            state <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
            tx <= tx_adv;
            O_mosi <= tx_adv[W-1:W-2];
            O_sck <= 2'b01;
            state <= DRIVE;
          end
        end else pcnt <= pcnt + PW'(1);
        default: begin
          O_done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tspi_master.sv
// tb_tspi_master: scoreboard bench for tspi_master with TRITS=3, CLK_DIV=2 and a looped-back I_miso
module tb_tspi_master;
  logic I_clk = 1'b0, I_rst = 1'b1, I_start = 1'b0;
  logic [5:0] I_tx_data = '0, O_rx_data;
  logic O_busy, O_done, O_err;
  logic [1:0] O_mosi, O_sck, I_miso;
  logic force_ill = 1'b0;
  logic [6:0] exp_q[$];
  int vectors = 0, miscompares = 0, n_done = 0;
  tspi_master #(.TRITS(3), .CLK_DIV(2)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_tx_data(I_tx_data),
    .O_busy(O_busy), .O_done(O_done), .O_rx_data(O_rx_data), .O_err(O_err),
    .O_mosi(O_mosi), .I_miso(I_miso), .O_sck(O_sck)
  );
  assign I_miso = force_ill ? 2'b11 : O_mosi;
  always #5 I_clk = ~I_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge I_clk) begin
    if (O_done) begin
      logic [6:0] e;
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rx_data", 32'(O_rx_data), 32'(e[5:0]));
        chk("err_at_done", 32'(O_err), 32'(e[6]));
      end
    end
  end
  task automatic xfer(input logic [5:0] tx, input logic [5:0] emosi, input logic [5:0] erx,
                      input logic eerr, input logic ill, input logic busy_pulse);
    int done_cyc = 0;
    logic [5:0] mseq = '0;
    exp_q.push_back({eerr, erx});
    I_tx_data = tx;
    I_start = 1'b1;
    @(negedge I_clk);
    for (int c = 1; c <= 30 && done_cyc == 0; c++) begin
      I_start = busy_pulse && c == 5;
      if (busy_pulse && c == 5) I_tx_data = 6'b100001;
      force_ill = ill && c >= 5 && c <= 8;
      if (c == 1) begin
        chk("busy_c1", 32'(O_busy), 1);
        chk("sck_c1", 32'(O_sck), 32'(2'b01));
        chk("err_cleared", 32'(O_err), 0);
      end
      if (c % 4 == 1 && O_sck == 2'b01) mseq = {mseq[3:0], O_mosi};
      if (O_done) done_cyc = c;
      if (done_cyc == 0) @(negedge I_clk);
    end
    force_ill = 1'b0;
    chk("done_cycle", 32'(done_cyc), 13);
    chk("mosi_seq", 32'(mseq), 32'(emosi));
  endtask
  initial begin
    int bad, n0;
    repeat (2) @(negedge I_clk);
    chk("reset_outs", 32'({O_busy, O_done, O_rx_data, O_err, O_mosi, O_sck}), 0);
    I_rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge I_clk);
      if ({O_mosi, O_sck} != 4'b0 || O_busy || O_done) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);
    xfer(6'b01_10_00, 6'b01_10_00, 6'b01_10_00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge I_clk);
    chk("rx_hold", 32'(O_rx_data), 32'(6'b011000));
    xfer(6'b01_01_01, 6'b01_01_01, 6'b01_00_01, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge I_clk);
    chk("err_sticky", 32'(O_err), 1);
    xfer(6'b11_01_10, 6'b00_01_10, 6'b00_01_10, 1'b0, 1'b0, 1'b0);
    @(negedge I_clk);
    n0 = n_done;
    xfer(6'b10_01_00, 6'b10_01_00, 6'b10_01_00, 1'b0, 1'b0, 1'b1);
    @(negedge I_clk);
    chk("busy_after_done", 32'(O_busy), 0);
    repeat (20) @(negedge I_clk);
    chk("one_done", 32'(n_done - n0), 1);
    n0 = n_done;
    I_tx_data = 6'b01_10_01;
    I_start = 1'b1;
    @(negedge I_clk);
    I_start = 1'b0;
    repeat (6) @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    chk("midreset_outs", 32'({O_busy, O_done, O_rx_data, O_err, O_mosi, O_sck}), 0);
    I_rst = 1'b0;
    repeat (20) @(negedge I_clk);
    chk("no_done_after_abort", 32'(n_done - n0), 0);
    xfer(6'b01_00_10, 6'b01_00_10, 6'b01_00_10, 1'b0, 1'b0, 1'b0);
    @(negedge I_clk);
    chk("idle_b2b", 32'({O_busy, O_done}), 0);
    xfer(6'b10_10_10, 6'b10_10_10, 6'b10_10_10, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge I_clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
